fifo_flagged: RTL and testbench

Parametrised synchronous FIFO: the next generation of the team's single-clock buffer. It adds simultaneous read/write, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain. It takes clean, single-cycle, clock-synchronous push/pop strobes; any debouncing or edge detection happens upstream.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr.sv | 35 +++
 rtl/fifo_flagged.sv | 133 +++++++++++++
 tb/tb_fifo_flagged.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the flagged FIFO: pointer/count widths and the wrapping
// pointer increment used by both FIFO pointers.
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-two depths never rely on natural rollover.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with an advance enable; instantiated once for the
// write side and once for the read side of the FIFO.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = PTR_W'(ptr_next(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clr_err,
    output logic [DATA_W-1:0]           data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    if (DATA_W < 1 || DEPTH < 2 || !(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_params
        $fatal(1, "fifo_flagged: illegal parameters (need DATA_W>=1, DEPTH>=2, AE_LEVEL < AF_LEVEL <= DEPTH)");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              pop_ok;
    logic              push_ok;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_FULL);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (push_ok),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pop_ok),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // New error events are OR-ed in after the clear so a same-cycle set wins.
    always_comb begin
        ovf_d = (ovf_q & ~clr_err) | (push & ~push_ok);
        unf_d = (unf_q & ~clr_err) | (pop & empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = mem_q[rd_ptr];
    end else begin : g_registered
        logic [DATA_W-1:0] dout_q;
        logic [DATA_W-1:0] dout_d;

        always_comb begin
            dout_d = dout_q;
            if (pop_ok) begin
                dout_d = mem_q[rd_ptr];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: a registered-read DEPTH=8 instance (A) and an FWFT DEPTH=5
// instance (B), each compared against a queue-based reference model.
module tb_fifo_flagged;

    localparam int DA  = 8;
    localparam int AFA = 6;
    localparam int AEA = 1;
    localparam int DB  = 5;
    localparam int AFB = 4;
    localparam int AEB = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dataInA, dataOutA, dataInB, dataOutB;
    logic       pushA, popA, clrA, pushB, popB, clrB;
    logic       fullA, emptyA, afA, aeA, ovfA, unfA;
    logic       fullB, emptyB, afB, aeB, ovfB, unfB;
    logic [3:0] countA;
    logic [2:0] countB;

    int checks = 0;
    int errors = 0;

    logic [7:0] modelA[$];
    logic [7:0] modelB[$];
    logic [7:0] expQA[$];
    logic       mOvfA, mUnfA, mOvfB, mUnfB;
    logic [7:0] mDoutA;

    fifo_flagged #(.DATA_W(8), .DEPTH(DA), .AF_LEVEL(AFA), .AE_LEVEL(AEA), .FWFT(0)) dutA (
        .clk(clk), .rst(rst), .data_in(dataInA), .push(pushA), .pop(popA), .clr_err(clrA),
        .data_out(dataOutA), .full(fullA), .empty(emptyA), .almost_full(afA),
        .almost_empty(aeA), .count(countA), .overflow(ovfA), .underflow(unfA)
    );

    fifo_flagged #(.DATA_W(8), .DEPTH(DB), .AF_LEVEL(AFB), .AE_LEVEL(AEB), .FWFT(1)) dutB (
        .clk(clk), .rst(rst), .data_in(dataInB), .push(pushB), .pop(popB), .clr_err(clrB),
        .data_out(dataOutB), .full(fullB), .empty(emptyB), .almost_full(afB),
        .almost_empty(aeB), .count(countB), .overflow(ovfB), .underflow(unfB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clearModels();
        modelA.delete();
        modelB.delete();
        mOvfA  = 1'b0;
        mUnfA  = 1'b0;
        mOvfB  = 1'b0;
        mUnfB  = 1'b0;
        mDoutA = 8'h00;
    endtask

    task automatic checkOutput();
        chk("countA", countA, modelA.size());
        chk("emptyA", emptyA, modelA.size() == 0);
        chk("fullA", fullA, modelA.size() == DA);
        chk("almostFullA", afA, modelA.size() >= AFA);
        chk("almostEmptyA", aeA, modelA.size() <= AEA);
        chk("overflowA", ovfA, mOvfA);
        chk("underflowA", unfA, mUnfA);
        chk("dataOutA", dataOutA, mDoutA);
        chk("countB", countB, modelB.size());
        chk("emptyB", emptyB, modelB.size() == 0);
        chk("fullB", fullB, modelB.size() == DB);
        chk("almostFullB", afB, modelB.size() >= AFB);
        chk("almostEmptyB", aeB, modelB.size() <= AEB);
        chk("overflowB", ovfB, mOvfB);
        chk("underflowB", unfB, mUnfB);
        if (modelB.size() > 0) chk("dataOutB head", dataOutB, modelB[0]);
    endtask

    // Drives one cycle of requests, advances both reference models and checks after the edge.
    task automatic applyStimulus(input logic pa, input logic qa, input logic [7:0] da, input logic ca,
                                 input logic pb, input logic qb, input logic [7:0] db, input logic cb);
        int szA, szB;
        bit popOkA, pushOkA, popOkB, pushOkB;
        szA = modelA.size();
        szB = modelB.size();
        popOkA  = qa && (szA > 0);
        pushOkA = pa && ((szA < DA) || popOkA);
        popOkB  = qb && (szB > 0);
        pushOkB = pb && ((szB < DB) || popOkB);
        pushA = pa; popA = qa; dataInA = da; clrA = ca;
        pushB = pb; popB = qb; dataInB = db; clrB = cb;
        if (ca) begin mOvfA = 1'b0; mUnfA = 1'b0; end
        if (pa && !pushOkA) mOvfA = 1'b1;
        if (qa && szA == 0) mUnfA = 1'b1;
        if (popOkA) begin
            mDoutA = modelA.pop_front();
            expQA.push_back(mDoutA);
        end
        if (pushOkA) modelA.push_back(da);
        if (cb) begin mOvfB = 1'b0; mUnfB = 1'b0; end
        if (pb && !pushOkB) mOvfB = 1'b1;
        if (qb && szB == 0) mUnfB = 1'b1;
        if (popOkB) void'(modelB.pop_front());
        if (pushOkB) modelB.push_back(db);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    // Monitor: whenever A accepts a pop, the registered read word must match the scoreboard head.
    initial begin : monitorA
        logic seen;
        forever begin
            @(posedge clk);
            seen = rst && popA && !emptyA;
            @(negedge clk);
            if (seen) begin
                if (expQA.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL monitorA unexpected read actual=%0h expected=none", dataOutA);
                end else begin
                    chk("monitorA data", dataOutA, expQA.pop_front());
                end
            end
        end
    end

    initial begin
        int pushPct[4] = '{75, 25, 50, 90};
        int popPct[4]  = '{25, 75, 50, 60};
        int ph;
        rst = 1'b0;
        pushA = 0; popA = 0; clrA = 0; dataInA = 0;
        pushB = 0; popB = 0; clrB = 0; dataInB = 0;
        clearModels();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput();
        chk("reset dataOutA", dataOutA, 8'h00);
        chk("reset emptyA", emptyA, 1'b1);
        chk("reset almostEmptyA", aeA, 1'b1);

        applyStimulus(1, 0, 8'hA5, 0, 0, 0, 8'h00, 0);
        chk("push A5 count", countA, 4'd1);
        chk("push A5 empty", emptyA, 1'b0);
        applyStimulus(0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        chk("pop A5 data", dataOutA, 8'hA5);

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 0, 8'(i), 0, 0, 0, 8'h00, 0);
            if (i == 5) chk("almostFull after 5", afA, 1'b0);
            if (i == 6) chk("almostFull after 6", afA, 1'b1);
            if (i == 7) chk("full after 7", fullA, 1'b0);
            if (i == 8) chk("full after 8", fullA, 1'b1);
        end
        applyStimulus(1, 0, 8'h99, 0, 0, 0, 8'h00, 0);
        chk("9th push overflow", ovfA, 1'b1);
        chk("9th push count", countA, 4'd8);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("clr overflow", ovfA, 1'b0);
        applyStimulus(1, 1, 8'h55, 0, 0, 0, 8'h00, 0);
        chk("full push+pop count", countA, 4'd8);
        chk("full push+pop full", fullA, 1'b1);
        chk("full push+pop overflow", ovfA, 1'b0);
        chk("full push+pop data", dataOutA, 8'h01);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        chk("last read 55", dataOutA, 8'h55);
        chk("drained emptyA", emptyA, 1'b1);

        applyStimulus(1, 1, 8'h77, 0, 0, 0, 8'h00, 0);
        chk("empty push+pop count", countA, 4'd1);
        chk("empty push+pop underflow", unfA, 1'b1);
        applyStimulus(0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("clr with new underflow", unfA, 1'b1);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        chk("clr underflow alone", unfA, 1'b0);

        applyStimulus(0, 0, 8'h00, 0, 1, 0, 8'h3C, 0);
        chk("fwft 3C visible", dataOutB, 8'h3C);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
        chk("fwft pop empty", emptyB, 1'b1);
        applyStimulus(0, 0, 8'h00, 0, 1, 0, 8'h11, 0);
        applyStimulus(0, 0, 8'h00, 0, 1, 0, 8'h22, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
        chk("fwft 22 after pop", dataOutB, 8'h22);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 8'h00, 0);

        for (int i = 0; i < 13; i++) applyStimulus(0, 0, 8'h00, 0, 1, (i >= 3), 8'(8'h40 + i), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
        chk("wrap drained emptyB", emptyB, 1'b1);

        for (int i = 0; i < 800; i++) begin
            ph = (i / 100) % 4;
            applyStimulus($urandom_range(0, 99) < pushPct[ph], $urandom_range(0, 99) < popPct[ph],
                          8'($urandom), $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < pushPct[ph], $urandom_range(0, 99) < popPct[ph],
                          8'($urandom), $urandom_range(0, 99) < 4);
        end

        for (int i = 0; i < DA && modelA.size() > 0; i++) applyStimulus(0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'(8'hD0 + i), 0, 1, 0, 8'(8'hB0 + i), 0);
        chk("pre-reset countA", countA, 4'd4);
        #2 rst = 1'b0;
        #1;
        chk("async reset countA", countA, 4'd0);
        chk("async reset emptyA", emptyA, 1'b1);
        chk("async reset dataOutA", dataOutA, 8'h00);
        chk("async reset countB", countB, 3'd0);
        clearModels();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput();
        applyStimulus(1, 0, 8'hE1, 0, 1, 0, 8'hC3, 0);
        chk("post-reset fwft head", dataOutB, 8'hC3);
        applyStimulus(1, 1, 8'hE2, 0, 0, 0, 8'h00, 0);
        chk("post-reset first read", dataOutA, 8'hE1);
        applyStimulus(0, 1, 8'h00, 0, 0, 1, 8'h00, 0);
        chk("post-reset second read", dataOutA, 8'hE2);

        applyStimulus(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        chk("scoreboard drained", expQA.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
